// File: rtl/add17_arbiter.sv
// Two-requester round-robin front end for a single 17-bit adder.
// Operands are captured into private registers at the grant edge, held on
// the adder for ADD_CYCLES cycles, and the result is registered together
// with a one-cycle done pulse for the winning requester.

// Plain 17-bit adder with carry out; the arbiter is its only user.
module adder17 (
  input  logic [16:0] A,
  input  logic [16:0] B,
  output logic [16:0] S,
  output logic        Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B};

endmodule

module add17_arbiter #(
  parameter int unsigned ADD_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [16:0] a0,
  input  logic [16:0] b0,
  input  logic [16:0] a1,
  input  logic [16:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [16:0] sum,
  output logic        cout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter is loaded with ADD_CYCLES-1 so that a zero count marks the
  // capture cycle; 4 bits cover the whole legal parameter range.
  localparam logic [3:0] CNT_LOAD = 4'(ADD_CYCLES - 1);

  state_e      state_q;
  logic        owner_q;   // 0 = requester 0, 1 = requester 1
  logic        last_q;    // requester served most recently
  logic [3:0]  cnt_q;
  logic [16:0] opa_q;
  logic [16:0] opb_q;
  logic [16:0] sum_q;
  logic        cout_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic        busy_q;

  logic        owner_d;
  logic [16:0] add_s;
  logic        add_c;

  // The only adder; it sees nothing but the captured operand registers, so
  // later operand changes at the ports cannot disturb an in-flight sum.
  adder17 u_add (
    .A    (opa_q),
    .B    (opb_q),
    .S    (add_s),
    .Cout (add_c)
  );

  // Winner selection: a lone requester wins; on a tie the one not served
  // last time wins.
  always_comb begin
    owner_d = 1'b0;
    if (req0 && req1) owner_d = ~last_q;
    else if (req1)    owner_d = 1'b1;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            owner_q <= owner_d;
            opa_q   <= owner_d ? a1 : a0;
            opb_q   <= owner_d ? b1 : b0;
            gnt0_q  <= ~owner_d;
            gnt1_q  <= owner_d;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            sum_q   <= add_s;
            cout_q  <= add_c;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_add17_arbiter.sv
// Bench for add17_arbiter: two instances (ADD_CYCLES = 1 and 4) each
// shadowed cycle by cycle by a transaction-level model, plus a vector table
// and hand-written sequences for ties, latency, operand changes and reset.
module tb_add17_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 [2];
  logic        req1 [2];
  logic [16:0] a0 [2];
  logic [16:0] b0 [2];
  logic [16:0] a1 [2];
  logic [16:0] b1 [2];
  logic        gnt0 [2];
  logic        gnt1 [2];
  logic        done0 [2];
  logic        done1 [2];
  logic [16:0] sum [2];
  logic        cout [2];
  logic        busy [2];

  int errors  = 0;
  int checks  = 0;
  int rst_cnt = 0;

  always #5 clk = ~clk;

  add17_arbiter #(.ADD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req0(req0[0]), .req1(req1[0]),
    .a0(a0[0]), .b0(b0[0]), .a1(a1[0]), .b1(b1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .sum(sum[0]), .cout(cout[0]), .busy(busy[0])
  );

  add17_arbiter #(.ADD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req0(req0[1]), .req1(req1[1]),
    .a0(a0[1]), .b0(b0[1]), .a1(a1[1]), .b1(b1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .sum(sum[1]), .cout(cout[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

  // Reference model: tracks the elapsed cycles of the current transaction.
  // e = 0 idle, 1..AC add in progress (grant high), AC+1 result cycle.
  for (genvar k = 0; k < 2; k++) begin : g_m
    localparam int ACK = (k == 0) ? 1 : 4;
    int          e = 0;
    bit          own = 1'b0;
    bit          last = 1'b1;
    logic [17:0] res = '0;
    logic [16:0] msum = '0;
    bit          mcout = 1'b0;
    logic        win;
    logic        mg;
    logic        md;
    logic [22:0] mexp;
    logic [22:0] mact;
    logic [17:0] prev = '0;
    int          prst = 0;

    assign win  = (req0[k] && req1[k]) ? !last : req1[k];
    assign mg   = (e >= 1) && (e <= ACK);
    assign md   = (e == ACK + 1);
    assign mexp = {mg && !own, mg && own, md && !own, md && own, e != 0, mcout, msum};
    assign mact = {gnt0[k], gnt1[k], done0[k], done1[k], busy[k], cout[k], sum[k]};

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e <= 0; last <= 1'b1; own <= 1'b0; res <= '0; msum <= '0; mcout <= 1'b0;
      end else if (e == 0) begin
        if (req0[k] || req1[k]) begin
          own <= win;
          res <= win ? ({1'b0, a1[k]} + {1'b0, b1[k]}) : ({1'b0, a0[k]} + {1'b0, b0[k]});
          e   <= 1;
        end
      end else if (e <= ACK) begin
        e <= e + 1;
        if (e == ACK) {mcout, msum} <= res;
      end else begin
        e    <= 0;
        last <= own;
      end
    end

    always @(negedge clk) begin
      check($sformatf("model_ac%0d", ACK), 32'(mact), 32'(mexp));
      check($sformatf("excl_ac%0d", ACK),
            32'((gnt0[k] & gnt1[k]) | (done0[k] & done1[k]) |
                ((gnt0[k] | gnt1[k]) & (done0[k] | done1[k]))), 32'd0);
      if (rst_cnt == prst && {cout[k], sum[k]} != prev)
        check($sformatf("sum_hold_ac%0d", ACK), 32'(done0[k] | done1[k]), 32'd1);
      prev <= {cout[k], sum[k]};
      prst <= rst_cnt;
    end
  end

  typedef struct {
    bit          r0;
    bit          r1;
    logic [16:0] a0;
    logic [16:0] b0;
    logic [16:0] a1;
    logic [16:0] b1;
    bit          win;
    logic [16:0] s;
    bit          c;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Applied back to back on the ADD_CYCLES=1 instance; ties alternate
    // starting with requester 0 because reset marks requester 1 as last.
    tbl[0] = '{1'b1, 1'b0, 17'h06667, 17'h18001, 17'h0,     17'h0,     1'b0, 17'h1E668, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 17'h0,     17'h0,     17'h1FFFF, 17'h00001, 1'b1, 17'h00000, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 17'h0AAAA, 17'h15555, 17'h00003, 17'h00004, 1'b0, 17'h1FFFF, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 17'h00003, 17'h00004, 17'h1ABCD, 17'h12345, 1'b1, 17'h0CF12, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 17'h00001, 17'h00000, 17'h1FFFF, 17'h1FFFF, 1'b0, 17'h00001, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 17'h1FFFF, 17'h1FFFF, 17'h0,     17'h0,     1'b0, 17'h1FFFE, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 17'h0,     17'h0,     17'h12345, 17'h00000, 1'b1, 17'h12345, 1'b0};

    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_ac1", 32'({gnt0[0], gnt1[0], done0[0], done1[0], busy[0], cout[0], sum[0]}), 32'd0);
    check("reset_outs_ac4", 32'({gnt0[1], gnt1[1], done0[1], done1[1], busy[1], cout[1], sum[1]}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table on the ADD_CYCLES=1 instance.
    for (int i = 0; i < 7; i++) begin
      int n; int gcnt; int other; bit seen;
      req0[0] = tbl[i].r0; req1[0] = tbl[i].r1;
      a0[0] = tbl[i].a0; b0[0] = tbl[i].b0; a1[0] = tbl[i].a1; b1[0] = tbl[i].b1;
      n = 0; gcnt = 0; other = 0; seen = 1'b0;
      while (!seen && n < 10) begin
        @(negedge clk);
        n++;
        if (tbl[i].win ? gnt1[0] : gnt0[0]) gcnt++;
        if (tbl[i].win ? (gnt0[0] | done0[0]) : (gnt1[0] | done1[0])) other++;
        if (done0[0] | done1[0]) seen = 1'b1;
      end
      check($sformatf("vec%0d_done_seen", i), 32'(seen), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd2);
      check($sformatf("vec%0d_winner", i), 32'({done0[0], done1[0]}), 32'({!tbl[i].win, tbl[i].win}));
      check($sformatf("vec%0d_sum", i), 32'({cout[0], sum[0]}), 32'({tbl[i].c, tbl[i].s}));
      check($sformatf("vec%0d_gnt_cycles", i), 32'(gcnt), 32'd1);
      check($sformatf("vec%0d_other_quiet", i), 32'(other), 32'd0);
      req0[0] = 1'b0; req1[0] = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'({busy[0], done0[0], done1[0]}), 32'd0);
    end

    // Both requesters held from reset: strict alternation every 3 cycles.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0[0] = 17'h00100; b0[0] = 17'h00023; a1[0] = 17'h1F000; b1[0] = 17'h01000;
    req0[0] = 1'b1; req1[0] = 1'b1;
    begin
      int nd; int lastn;
      nd = 0; lastn = 0;
      for (int n = 1; n <= 20 && nd < 4; n++) begin
        @(negedge clk);
        if (done0[0] | done1[0]) begin
          check($sformatf("rr%0d_owner", nd), 32'({done0[0], done1[0]}), (nd % 2 == 0) ? 32'd2 : 32'd1);
          check($sformatf("rr%0d_sum", nd), 32'({cout[0], sum[0]}), (nd % 2 == 0) ? 32'h00123 : 32'h20000);
          if (nd > 0) check($sformatf("rr%0d_spacing", nd), 32'(n - lastn), 32'd3);
          lastn = n;
          nd++;
        end
      end
      check("rr_done_count", 32'(nd), 32'd4);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    repeat (3) @(negedge clk);

    // ADD_CYCLES=4: grant for four cycles, done on the fifth, operand
    // change after the grant edge must not leak into the result.
    a0[1] = 17'h01234; b0[1] = 17'h00FFF; req0[1] = 1'b1;
    begin
      int gcnt; int dpos;
      gcnt = 0; dpos = 0;
      for (int n = 1; n <= 10 && dpos == 0; n++) begin
        @(negedge clk);
        if (n == 1) a0[1] = 17'h00000;
        if (gnt0[1]) gcnt++;
        if (done0[1]) dpos = n;
      end
      check("ac4_gnt_cycles", 32'(gcnt), 32'd4);
      check("ac4_done_pos", 32'(dpos), 32'd5);
      check("ac4_sum", 32'({cout[1], sum[1]}), 32'h02233);
    end
    req0[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an ADD discards the operation.
    a0[1] = 17'h00005; b0[1] = 17'h00007; req0[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outs_ac4", 32'({gnt0[1], gnt1[1], done0[1], done1[1], busy[1], cout[1], sum[1]}), 32'd0);
    req0[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dn;
      dn = 0;
      repeat (8) begin
        @(negedge clk);
        if (done0[1] | done1[1]) dn++;
      end
      check("midrst_no_done", 32'(dn), 32'd0);
      check("midrst_sum_kept", 32'({cout[1], sum[1]}), 32'd0);
    end
    a1[1] = 17'h0FFFF; b1[1] = 17'h00001; req1[1] = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        if (done0[1] | done1[1]) seen = 1'b1;
      end
      check("postrst_done1", 32'({seen, done0[1], done1[1]}), 32'b101);
      check("postrst_sum", 32'({cout[1], sum[1]}), 32'h10000);
    end
    req1[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic on both instances, checked by the per-cycle model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!req0[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            a0[k] = 17'($urandom); b0[k] = 17'($urandom); req0[k] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) req0[k] = 1'b0;
        if (!req1[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            a1[k] = 17'($urandom); b1[k] = 17'($urandom); req1[k] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) req1[k] = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
